// File: rtl/mem_pkg.sv
// Shared types and constants for the core-side memory controller.
package mem_pkg;

    localparam logic [2:0] SIZE_BYTE = 3'd1;
    localparam logic [2:0] SIZE_WORD = 3'd2;
    localparam int unsigned RAM_BYTES = 2048;
    localparam logic [15:0] ADDR_LAST = 16'(RAM_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_READ,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic        write;
        logic [2:0]  size;
        logic        sgn;
        logic [15:0] addr;
        logic [15:0] data;
    } mem_req_t;

    // A word touches addr and addr+1, so its last legal start is one lower.
    function automatic logic req_legal(input logic [2:0] size,
                                       input logic [15:0] addr);
        logic ok;
        ok = 1'b0;
        if (size == SIZE_BYTE)
            ok = (addr <= ADDR_LAST);
        else if (size == SIZE_WORD)
            ok = (addr < ADDR_LAST);
        return ok;
    endfunction

endpackage

// File: rtl/mem_ctrl_load_format.sv
// Load-data formatting: byte sign/zero extension or word passthrough.
module mem_load_format
    import mem_pkg::*;
(
    input  logic [2:0]  size,
    input  logic        sign_ext,
    input  logic [15:0] raw_data,
    output logic [15:0] fmt_data
);

    always_comb begin
        fmt_data = raw_data;
        if (size != SIZE_WORD) begin
            if (sign_ext)
                fmt_data = {{8{raw_data[7]}}, raw_data[7:0]};
            else
                fmt_data = {8'h00, raw_data[7:0]};
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Single-outstanding memory controller: request check, one RAM
// access cycle, optional read formatting, held response.
module mem_ctrl
    import mem_pkg::*;
(
    input  logic        I_clk,
    input  logic        I_reset_n,
    input  logic        I_req_valid,
    output logic        O_req_ready,
    input  logic        I_req_write,
    input  logic [2:0]  I_req_size,
    input  logic        I_req_signed,
    input  logic [15:0] I_req_addr,
    input  logic [15:0] I_req_data,
    output logic        O_resp_valid,
    input  logic        I_resp_ready,
    output logic [15:0] O_resp_data,
    output logic        O_resp_error,
    output logic        O_ram_enable,
    output logic        O_ram_write,
    output logic [2:0]  O_ram_size,
    output logic [15:0] O_ram_addr,
    output logic [15:0] O_ram_data,
    input  logic [15:0] I_ram_data
);

    state_t      state_q, state_d;
    mem_req_t    req_q;
    logic [15:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [15:0] load_fmt;
    logic        accept;

    assign O_req_ready = (state_q == ST_IDLE) && I_reset_n;
    assign accept      = I_req_valid && O_req_ready;

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept)
                req_q <= '{write: I_req_write, size: I_req_size,
                           sgn: I_req_signed, addr: I_req_addr,
                           data: I_req_data};
        end
    end

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    rdata_d = '0;
                    if (req_legal(I_req_size, I_req_addr)) begin
                        err_d   = 1'b0;
                        state_d = ST_ACCESS;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_ACCESS: state_d = req_q.write ? ST_RESP : ST_READ;
            ST_READ: begin
                rdata_d = load_fmt;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (I_resp_ready) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    mem_load_format u_fmt (
        .size     (req_q.size),
        .sign_ext (req_q.sgn),
        .raw_data (I_ram_data),
        .fmt_data (load_fmt)
    );

    // Gating with the raw reset drops enable in the same instant reset hits.
    assign O_ram_enable = (state_q == ST_ACCESS) && I_reset_n;
    assign O_ram_write  = O_ram_enable ? req_q.write : 1'b0;
    assign O_ram_size   = O_ram_enable ? req_q.size  : 3'd0;
    assign O_ram_addr   = O_ram_enable ? req_q.addr  : 16'd0;
    assign O_ram_data   = O_ram_enable ? req_q.data  : 16'd0;

    assign O_resp_valid = (state_q == ST_RESP);
    assign O_resp_data  = rdata_q;
    assign O_resp_error = err_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl with a byte-array RAM and reference model.
module tb_mem_ctrl;

    logic        I_clk = 1'b0;
    logic        I_reset_n = 1'b0;
    logic        I_req_valid = 1'b0;
    logic        O_req_ready;
    logic        I_req_write = 1'b0;
    logic [2:0]  I_req_size = 3'd0;
    logic        I_req_signed = 1'b0;
    logic [15:0] I_req_addr = 16'd0;
    logic [15:0] I_req_data = 16'd0;
    logic        O_resp_valid;
    logic        I_resp_ready = 1'b0;
    logic [15:0] O_resp_data;
    logic        O_resp_error;
    logic        O_ram_enable;
    logic        O_ram_write;
    logic [2:0]  O_ram_size;
    logic [15:0] O_ram_addr;
    logic [15:0] O_ram_data;
    logic [15:0] I_ram_data;

    mem_ctrl dut (
        .I_clk        (I_clk),
        .I_reset_n    (I_reset_n),
        .I_req_valid  (I_req_valid),
        .O_req_ready  (O_req_ready),
        .I_req_write  (I_req_write),
        .I_req_size   (I_req_size),
        .I_req_signed (I_req_signed),
        .I_req_addr   (I_req_addr),
        .I_req_data   (I_req_data),
        .O_resp_valid (O_resp_valid),
        .I_resp_ready (I_resp_ready),
        .O_resp_data  (O_resp_data),
        .O_resp_error (O_resp_error),
        .O_ram_enable (O_ram_enable),
        .O_ram_write  (O_ram_write),
        .O_ram_size   (O_ram_size),
        .O_ram_addr   (O_ram_addr),
        .O_ram_data   (O_ram_data),
        .I_ram_data   (I_ram_data)
    );

    always #5 I_clk = ~I_clk;

    typedef struct {
        logic [15:0] data;
        logic        err;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad = 0;
    int         en_cnt = 0;
    logic [7:0] ram [0:2047];
    logic [7:0] ref_mem [0:2047];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // External RAM: registers read data on the edge ending the access.
    always @(posedge I_clk) begin
        if (O_ram_enable) begin
            en_cnt++;
            if (O_ram_write) begin
                ram[O_ram_addr[10:0]] <= O_ram_data[7:0];
                if (O_ram_size == 3'd2)
                    ram[11'(O_ram_addr + 16'd1)] <= O_ram_data[15:8];
            end else begin
                I_ram_data <= {(O_ram_size == 3'd2)
                               ? ram[11'(O_ram_addr + 16'd1)]
                               : 8'($urandom),
                               ram[O_ram_addr[10:0]]};
            end
        end
    end

    // Monitor: every presented response must match the scoreboard head.
    always @(negedge I_clk) begin
        if (I_reset_n && O_resp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                chk("resp_data", 32'(O_resp_data), 32'(sb[0].data));
                chk("resp_error", 32'(O_resp_error), 32'(sb[0].err));
                if (I_resp_ready)
                    void'(sb.pop_front());
            end
        end
    end

    task automatic do_req(input logic w, input logic [2:0] sz,
                          input logic sg, input logic [15:0] a,
                          input logic [15:0] d, input int stall);
        exp_t       e;
        logic       legal;
        int         exp_lat, exp_en, lat, k, en0;
        logic [7:0] b;
        legal = (sz == 3'd1 || sz == 3'd2)
                && (int'(a) + int'(sz) <= 2048);
        if (!legal) begin
            e = '{data: 16'd0, err: 1'b1};
            exp_lat = 1;
            exp_en = 0;
        end else if (w) begin
            ref_mem[a] = d[7:0];
            if (sz == 3'd2)
                ref_mem[int'(a) + 1] = d[15:8];
            e = '{data: 16'd0, err: 1'b0};
            exp_lat = 2;
            exp_en = 1;
        end else begin
            b = ref_mem[a];
            if (sz == 3'd2)
                e.data = 16'(int'(ref_mem[int'(a) + 1]) * 256 + int'(b));
            else if (sg && b >= 8'd128)
                e.data = 16'(int'(b) - 256);
            else
                e.data = 16'(b);
            e.err = 1'b0;
            exp_lat = 3;
            exp_en = 1;
        end
        sb.push_back(e);
        I_req_write  = w;
        I_req_size   = sz;
        I_req_signed = sg;
        I_req_addr   = a;
        I_req_data   = d;
        I_req_valid  = 1'b1;
        I_resp_ready = (stall == 0);
        k = 0;
        while (!O_req_ready && k < 20) begin
            @(posedge I_clk); #1;
            k++;
        end
        if (k == 20) chk("req_ready_timeout", 32'd1, 32'd0);
        @(posedge I_clk); #1;
        I_req_valid = 1'b0;
        en0 = en_cnt;
        lat = 1;
        while (!O_resp_valid && lat < 20) begin
            @(posedge I_clk); #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        for (int i = 0; i < stall; i++) begin
            chk("req_ready_in_resp", 32'(O_req_ready), 32'd0);
            @(posedge I_clk); #1;
        end
        I_resp_ready = 1'b1;
        @(posedge I_clk); #1;
        chk("req_ready_after_hs", 32'(O_req_ready), 32'd1);
        chk("resp_valid_after_hs", 32'(O_resp_valid), 32'd0);
        chk("ram_enables", 32'(en_cnt - en0), 32'(exp_en));
    endtask

    initial begin
        logic [7:0]  v;
        logic [2:0]  sz;
        logic [15:0] a;
        int          en0, st;
        for (int i = 0; i < 2048; i++) begin
            v = 8'($urandom);
            ram[i] <= v;
            ref_mem[i] = v;
        end
        #12;
        chk("rst_req_ready", 32'(O_req_ready), 32'd0);
        chk("rst_resp_valid", 32'(O_resp_valid), 32'd0);
        chk("rst_resp_error", 32'(O_resp_error), 32'd0);
        chk("rst_resp_data", 32'(O_resp_data), 32'd0);
        chk("rst_ram_enable", 32'(O_ram_enable), 32'd0);
        chk("rst_ram_bus", {O_ram_addr, O_ram_data}, 32'd0);
        I_reset_n = 1'b1;
        @(posedge I_clk); #1;
        chk("ready_after_rst", 32'(O_req_ready), 32'd1);

        do_req(1'b1, 3'd2, 1'b0, 16'h0010, 16'h1234, 0);
        do_req(1'b0, 3'd2, 1'b0, 16'h0010, 16'h0000, 0);
        do_req(1'b1, 3'd1, 1'b0, 16'h0020, 16'h5580, 0);
        do_req(1'b0, 3'd1, 1'b1, 16'h0020, 16'h0000, 0);
        do_req(1'b0, 3'd1, 1'b0, 16'h0020, 16'h0000, 0);
        do_req(1'b0, 3'd2, 1'b0, 16'h07FF, 16'h0000, 0);
        do_req(1'b0, 3'd1, 1'b0, 16'h0800, 16'h0000, 0);
        do_req(1'b0, 3'd3, 1'b0, 16'h0100, 16'h0000, 0);
        do_req(1'b1, 3'd2, 1'b0, 16'hFFFF, 16'hBEEF, 0);
        do_req(1'b1, 3'd2, 1'b0, 16'h07FE, 16'hA5C3, 0);
        do_req(1'b0, 3'd2, 1'b0, 16'h07FE, 16'h0000, 0);
        do_req(1'b0, 3'd1, 1'b1, 16'h07FF, 16'h0000, 0);
        do_req(1'b0, 3'd2, 1'b0, 16'h0010, 16'h0000, 5);

        // Abort a store while its RAM access is on the bus.
        I_req_write = 1'b1;
        I_req_size  = 3'd2;
        I_req_addr  = 16'h0040;
        I_req_data  = 16'hDEAD;
        I_req_valid = 1'b1;
        @(posedge I_clk); #1;
        I_req_valid = 1'b0;
        chk("abort_en_in_access", 32'(O_ram_enable), 32'd1);
        en0 = en_cnt;
        I_reset_n = 1'b0;
        #1;
        chk("abort_en_drop", 32'(O_ram_enable), 32'd0);
        chk("abort_resp_valid", 32'(O_resp_valid), 32'd0);
        chk("abort_req_ready", 32'(O_req_ready), 32'd0);
        @(posedge I_clk); #1;
        @(posedge I_clk); #3;
        I_reset_n = 1'b1;
        @(posedge I_clk); #1;
        chk("abort_ready_after", 32'(O_req_ready), 32'd1);
        chk("abort_no_resp", 32'(O_resp_valid), 32'd0);
        chk("abort_no_enable", 32'(en_cnt - en0), 32'd0);
        do_req(1'b0, 3'd2, 1'b0, 16'h0040, 16'h0000, 0);

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) == 0)
                sz = ($urandom_range(0, 1) == 0) ? 3'd0
                     : 3'($urandom_range(3, 7));
            else
                sz = 3'($urandom_range(1, 2));
            if ($urandom_range(0, 4) == 0)
                a = 16'($urandom_range(16'h07FC, 16'h0803));
            else
                a = 16'($urandom_range(0, 63));
            st = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            do_req(1'($urandom), sz, 1'($urandom), a, 16'($urandom), st);
        end

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
